// File: rtl/mobius_iter_if.sv
// Streaming handshake bundle for the folded GF(2) Mobius transform.
// The master drives vectors in and accepts results; the slave is the transform block.
interface mobius_iter_if #(
    parameter int unsigned N = 256
);
    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [0:N-1] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mobius_iter.sv
// Folded binary Mobius transform: LOG2_N butterfly stages, STAGES_PER_CYCLE per clock.
// Mode 0 is the subset (truth table to ANF) transform, mode 1 the superset transform.
module mobius_iter #(
    parameter int unsigned N                = 256,
    parameter int unsigned LOG2_N           = 8,
    parameter int unsigned STAGES_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst,
    mobius_iter_if.slave bus
);
    localparam int unsigned CW = $clog2(LOG2_N + 1);
    localparam logic [CW-1:0] STEP = CW'(STAGES_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(LOG2_N - STAGES_PER_CYCLE);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("mobius_iter: N must be a power of two, at least 2");
    end
    if (LOG2_N != $clog2(N)) begin : g_bad_log2
        $error("mobius_iter: LOG2_N must equal $clog2(N)");
    end
    if (STAGES_PER_CYCLE == 0 || (LOG2_N % STAGES_PER_CYCLE) != 0) begin : g_bad_spc
        $error("mobius_iter: STAGES_PER_CYCLE must divide LOG2_N");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q;
    logic [0:N-1] work_q;
    logic [CW-1:0] cnt_q;
    logic         mode_q;
    logic [0:N-1] staged;
    int unsigned  cnt_int;

    // Index i lies in the upper half of its 2h block exactly when bit h of i is set.
    function automatic logic [0:N-1] apply_stage(input logic [0:N-1] w, input int unsigned s,
                                                 input logic m);
        logic [0:N-1] r;
        int unsigned  h;
        r = w;
        h = N >> (s + 1);
        for (int unsigned i = 0; i < N; i++) begin
            if (!m && (i & h) != 0) begin
                r[i] = w[i] ^ w[i - h];
            end else if (m && (i & h) == 0) begin
                r[i] = w[i] ^ w[i + h];
            end
        end
        return r;
    endfunction

    assign cnt_int = 32'(cnt_q);

    always_comb begin
        staged = work_q;
        for (int unsigned p = 0; p < STAGES_PER_CYCLE; p++) begin
            for (int unsigned st = 0; st < LOG2_N; st++) begin
                if (cnt_int + p == st) begin
                    staged = apply_stage(staged, st, mode_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_data;
                        mode_q  <= bus.in_mode;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q <= staged;
                    cnt_q  <= cnt_q + STEP;
                    if (cnt_q == LAST) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_data  = work_q;
endmodule
